// File: rtl/time_syn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : time_syn_pkg
// Description : Shared constants for the slot/sync beacon originator: frame
//               type default, frame length, beacon flag bit positions,
//               broadcast MAC and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package time_syn_pkg;

    localparam logic [15:0] C_SLOT_ID_TYPE = 16'hff03;
    localparam int          C_FRAME_LEN    = 8;
    localparam logic [2:0]  C_LAST_BEAT    = 3'(C_FRAME_LEN - 1);

    // Bit positions inside the beacon flag byte (low byte of beat 1)
    localparam int          C_FLAG_SLOT_ID = 0;
    localparam int          C_FLAG_SYN     = 1;

    localparam logic [47:0] C_BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

    // Serializer FSM encodings
    localparam logic [1:0]  S_IDLE         = 2'd0;
    localparam logic [1:0]  S_LOAD         = 2'd1;
    localparam logic [1:0]  S_SEND         = 2'd2;

endpackage
`default_nettype wire

// File: rtl/slot_beacon_tx_if.sv
`default_nettype none
// ============================================================================
// Interface   : slot_beacon_tx_if
// Description : 64-bit AXI-Stream TX bundle carrying beacon frames towards
//               the MAC TX arbiter.
//   master : drives tvalid/tdata/tlast/tkeep/tuser, samples tready
//   slave  : samples the payload signals, drives tready
// Revision    : 1.0 - initial release
// ============================================================================
interface slot_beacon_tx_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic        tlast;
    logic [7:0]  tkeep;
    logic        tuser;

    modport master (output tvalid, tdata, tlast, tkeep, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tkeep, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/slot_beacon_tx_timer.sv
`default_nettype none
// ============================================================================
// Module      : slot_timer
// Description : Free-running slot counter with slot-ID toggle, 16-bit beacon
//               sequence number and sync-period counter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_run          : counter runs while high, otherwise held at 0
//   o_boundary     : combinational, high on the last cycle of a slot
//   o_syn_flag     : sync-start flag for the beacon raised at this boundary
//   o_slot_start   : one-cycle pulse the cycle after a boundary
//   o_slot_id      : current (post-toggle) slot ID
//   o_seq          : current (post-increment) sequence number
// Revision    : 1.0 - initial release
// ============================================================================
module slot_timer #(
    parameter int P_SLOT_LEN   = 1000,
    parameter int P_SYN_PERIOD = 16
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic        i_run,
    output logic             o_boundary,
    output logic             o_syn_flag,
    output logic             o_slot_start,
    output logic             o_slot_id,
    output logic [15:0]      o_seq
);
    localparam logic [15:0] C_SLOT_LAST = 16'(P_SLOT_LEN - 1);
    localparam logic [7:0]  C_SYN_LAST  = 8'(P_SYN_PERIOD - 1);

    logic [15:0] slot_cnt_q, slot_cnt_d;
    logic [7:0]  syn_cnt_q,  syn_cnt_d;
    logic [15:0] seq_q,      seq_d;
    logic        slot_id_q,  slot_id_d;
    logic        slot_start_q;
    logic        w_boundary;

    assign w_boundary = i_run && (slot_cnt_q == C_SLOT_LAST);

    always_comb begin
        slot_cnt_d = slot_cnt_q + 16'd1;
        syn_cnt_d  = syn_cnt_q;
        seq_d      = seq_q;
        slot_id_d  = slot_id_q;
        if (!i_run) begin
            // Sync phase restarts on re-enable so the first beacon carries SYN
            slot_cnt_d = 16'd0;
            syn_cnt_d  = 8'd0;
        end else if (w_boundary) begin
            slot_cnt_d = 16'd0;
            syn_cnt_d  = (syn_cnt_q == C_SYN_LAST) ? 8'd0 : syn_cnt_q + 8'd1;
            seq_d      = seq_q + 16'd1;
            slot_id_d  = ~slot_id_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_cnt_q   <= 16'd0;
            syn_cnt_q    <= 8'd0;
            seq_q        <= 16'd0;
            slot_id_q    <= 1'b0;
            slot_start_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            syn_cnt_q    <= syn_cnt_d;
            seq_q        <= seq_d;
            slot_id_q    <= slot_id_d;
            slot_start_q <= w_boundary;
        end
    end

    assign o_boundary   = w_boundary;
    assign o_syn_flag   = (syn_cnt_q == 8'd0);
    assign o_slot_start = slot_start_q;
    assign o_slot_id    = slot_id_q;
    assign o_seq        = seq_q;
endmodule
`default_nettype wire

// File: rtl/slot_beacon_tx.sv
`default_nettype none
// ============================================================================
// Module      : slot_beacon_tx
// Description : Master-side slot/sync beacon originator. At every slot
//               boundary emits one 8-beat 64-bit AXI-Stream frame carrying
//               slot ID, sync flag, sequence number and local time.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_beacon_en      : beacon generation enable (level)
//   i_stat_rx_status : link up; beacons suppressed while low
//   i_local_time     : master local time, latched in LOAD
//   o_cur_slot_id    : current slot ID
//   o_slot_start     : pulse at each slot start
//   o_beacon_busy    : high from LOAD until tlast accepted
//   o_drop_cnt       : saturating count of dropped beacons
//   tx               : AXI-Stream master (tvalid/tready/tdata/tlast/tkeep/tuser)
// Revision    : 1.0 - initial release
// ============================================================================
module slot_beacon_tx
    import time_syn_pkg::*;
#(
    parameter int          P_SLOT_LEN     = 1000,
    parameter int          P_SYN_PERIOD   = 16,
    parameter logic [15:0] P_SLOT_ID_TYPE = C_SLOT_ID_TYPE,
    parameter logic [47:0] P_SRC_MAC      = 48'h00_0A_35_00_00_01
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic        i_beacon_en,
    input  wire logic        i_stat_rx_status,
    input  wire logic [63:0] i_local_time,
    output logic             o_cur_slot_id,
    output logic             o_slot_start,
    output logic             o_beacon_busy,
    output logic [15:0]      o_drop_cnt,
    slot_beacon_tx_if.master tx
);
    logic        w_boundary, w_syn_flag, w_slot_id;
    logic [15:0] w_seq;

    logic [1:0]  state_q, state_d;
    logic [2:0]  beat_q;
    logic        syn_pend_q;
    logic        fr_slot_id_q, fr_syn_q;
    logic [15:0] fr_seq_q;
    logic [63:0] fr_time_q;
    logic [15:0] drop_cnt_q;
    logic [7:0]  w_flags;

    slot_timer #(
        .P_SLOT_LEN   (P_SLOT_LEN),
        .P_SYN_PERIOD (P_SYN_PERIOD)
    ) u_slot_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_run        (i_beacon_en && i_stat_rx_status),
        .o_boundary   (w_boundary),
        .o_syn_flag   (w_syn_flag),
        .o_slot_start (o_slot_start),
        .o_slot_id    (w_slot_id),
        .o_seq        (w_seq)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_boundary) state_d = S_LOAD;
            S_LOAD:  state_d = S_SEND;
            S_SEND:  if (tx.tready && beat_q == C_LAST_BEAT) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Frame datapath. Slot ID and seq are read in LOAD, i.e. after the
    // boundary update; the sync flag belongs to the boundary itself and is
    // captured there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_q       <= 3'd0;
            syn_pend_q   <= 1'b0;
            fr_slot_id_q <= 1'b0;
            fr_syn_q     <= 1'b0;
            fr_seq_q     <= 16'd0;
            fr_time_q    <= 64'd0;
            drop_cnt_q   <= 16'd0;
        end else begin
            if (state_q == S_IDLE && w_boundary) begin
                syn_pend_q <= w_syn_flag;
            end
            if (state_q == S_LOAD) begin
                fr_slot_id_q <= w_slot_id;
                fr_syn_q     <= syn_pend_q;
                fr_seq_q     <= w_seq;
                fr_time_q    <= i_local_time;
                beat_q       <= 3'd0;
            end else if (state_q == S_SEND && tx.tready) begin
                beat_q <= beat_q + 3'd1;
            end
            if (w_boundary && state_q != S_IDLE && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        w_flags                 = 8'd0;
        w_flags[C_FLAG_SLOT_ID] = fr_slot_id_q;
        w_flags[C_FLAG_SYN]     = fr_syn_q;
    end

    // Outputs: payload is a pure function of registers, so it holds while stalled
    always_comb begin
        tx.tvalid = (state_q == S_SEND);
        tx.tlast  = (state_q == S_SEND) && (beat_q == C_LAST_BEAT);
        tx.tkeep  = (state_q == S_SEND) ? 8'hFF : 8'h00;
        tx.tuser  = 1'b0;
        tx.tdata  = 64'd0;
        if (state_q == S_SEND) begin
            case (beat_q)
                3'd0:    tx.tdata = {C_BCAST_MAC, P_SRC_MAC[47:32]};
                3'd1:    tx.tdata = {P_SRC_MAC[31:0], P_SLOT_ID_TYPE, 8'h00, w_flags};
                3'd2:    tx.tdata = {48'd0, fr_seq_q};
                3'd3:    tx.tdata = fr_time_q;
                default: tx.tdata = 64'd0;
            endcase
        end
        o_beacon_busy = (state_q != S_IDLE);
    end

    assign o_cur_slot_id = w_slot_id;
    assign o_drop_cnt    = drop_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_slot_beacon_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_slot_beacon_tx
// Description : Scoreboard bench for slot_beacon_tx with slot length 32 and
//               sync period 4. A frame-level reference model predicts slot
//               pulses, slot ID, drops and frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slot_beacon_tx;
    localparam int          LEN = 32;
    localparam int          SYN = 4;
    localparam logic [47:0] MAC = 48'h00_0A_35_00_00_01;

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        link = 1'b1;
    logic [63:0] ltime = 64'd0;
    logic        slot_id, slot_start, busy;
    logic [15:0] drop;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_run_cycles;   // consecutive running cycles so far
    int          m_beacons;      // boundaries since the link/enable came up
    logic        m_id;
    logic [15:0] m_seq;
    logic [15:0] m_drop;
    logic        m_start;
    int          m_phase;        // 0 idle, 1 load, 2 send
    int          m_left;         // beats still to be accepted
    logic        m_syn;
    beat_t       q[$];

    slot_beacon_tx_if tx();

    slot_beacon_tx #(
        .P_SLOT_LEN   (LEN),
        .P_SYN_PERIOD (SYN)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_beacon_en      (en),
        .i_stat_rx_status (link),
        .i_local_time     (ltime),
        .o_cur_slot_id    (slot_id),
        .o_slot_start     (slot_start),
        .o_beacon_busy    (busy),
        .o_drop_cnt       (drop),
        .tx               (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        logic [63:0] b[8];
        b[0] = {48'hFFFF_FFFF_FFFF, MAC[47:32]};
        b[1] = {MAC[31:0], 16'hff03, 8'h00, 6'd0, m_syn, m_id};
        b[2] = {48'd0, m_seq};
        b[3] = ltime;
        for (int i = 4; i < 8; i++) b[i] = 64'd0;
        for (int i = 0; i < 8; i++) q.push_back('{d: b[i], l: (i == 7)});
    endtask

    task automatic model_reset();
        m_run_cycles = 0;
        m_beacons    = 0;
        m_id         = 1'b0;
        m_seq        = 16'd0;
        m_drop       = 16'd0;
        m_start      = 1'b0;
        m_phase      = 0;
        m_left       = 0;
        m_syn        = 1'b0;
        q.delete();
    endtask

    // Advance the model across one rising edge using the inputs seen at it
    task automatic model_edge();
        bit run, bnd, was_idle;
        run      = en && link;
        bnd      = run && ((m_run_cycles % LEN) == LEN - 1);
        was_idle = (m_phase == 0);
        m_start  = bnd;
        if (m_phase == 1) begin
            push_frame();
            m_phase = 2;
            m_left  = 8;
        end else if (m_phase == 2 && tx.tready) begin
            m_left--;
            if (m_left == 0) m_phase = 0;
        end
        if (bnd) begin
            bit syn_now;
            syn_now = ((m_beacons % SYN) == 0);
            m_beacons++;
            m_id  = ~m_id;
            m_seq = m_seq + 16'd1;
            if (was_idle) begin
                m_phase = 1;
                m_syn   = syn_now;
            end else if (m_drop != 16'hFFFF) begin
                m_drop = m_drop + 16'd1;
            end
        end
        if (run) m_run_cycles++;
        else begin
            m_run_cycles = 0;
            m_beacons    = 0;
        end
    endtask

    task automatic status_chk();
        chk("slot_start", 64'(slot_start), 64'(m_start));
        chk("slot_id", 64'(slot_id), 64'(m_id));
        chk("drop_cnt", 64'(drop), 64'(m_drop));
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("tvalid", 64'(tx.tvalid), 64'(m_phase == 2));
    endtask

    // mode: 0 tready high, 1 random tready, 2 tready low
    task automatic step(input int mode);
        @(posedge clk);
        #1;
        if (rst_n) begin
            model_edge();
            status_chk();
        end
        case (mode)
            0:       tx.tready = 1'b1;
            1:       tx.tready = 1'($urandom_range(0, 1));
            default: tx.tready = 1'b0;
        endcase
        ltime = {$urandom, $urandom};
    endtask

    // Run until the model shows the given number of beats still pending
    task automatic wait_left(input int left, input int mode);
        int k;
        k = 0;
        while (!(m_phase == 2 && m_left == left) && k < 300) begin
            step(mode);
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_beat: got timeout expected beat with %0d left", left);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 64'(tx.tvalid), 64'd0);
        chk("rst_tdata", tx.tdata, 64'd0);
        chk("rst_tlast", 64'(tx.tlast), 64'd0);
        chk("rst_tkeep", 64'(tx.tkeep), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_slot_id", 64'(slot_id), 64'd0);
        chk("rst_slot_start", 64'(slot_start), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        model_reset();
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops expected beats on each handshake and checks stall stability
    initial begin
        bit          stalled;
        logic [63:0] pd;
        logic        pl;
        beat_t       e;
        stalled = 1'b0;
        pd = 64'd0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("hold_tvalid", 64'(tx.tvalid), 64'd1);
                chk("hold_tdata", tx.tdata, pd);
                chk("hold_tlast", 64'(tx.tlast), 64'(pl));
            end
            if (tx.tvalid && tx.tready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got %h expected no beat", tx.tdata);
                end else begin
                    e = q.pop_front();
                    chk("beat_data", tx.tdata, e.d);
                    chk("beat_last", 64'(tx.tlast), 64'(e.l));
                    chk("beat_keep", 64'(tx.tkeep), 64'hFF);
                    chk("beat_user", 64'(tx.tuser), 64'd0);
                end
            end
            stalled = tx.tvalid && !tx.tready;
            pd = tx.tdata;
            pl = tx.tlast;
        end
    end

    initial begin
        tx.tready = 1'b1;
        model_reset();
        do_reset();
        en = 1'b1;

        // Steady beaconing with tready held high
        repeat (200) step(0);

        // 40-cycle stall starting at beat 2: next boundary is dropped
        wait_left(6, 0);
        tx.tready = 1'b0;
        repeat (39) step(2);
        step(0);
        chk("drop_after_stall", 64'(drop), 64'd1);
        repeat (100) step(0);

        // Random backpressure
        repeat (400) step(1);

        // Link falls during beat 4: frame completes, then silence
        wait_left(4, 1);
        link = 1'b0;
        repeat (60) step(1);
        chk("link_down_tvalid", 64'(tx.tvalid), 64'd0);
        chk("link_down_queue", 64'(q.size()), 64'd0);

        // Reset during beat 3, then re-enable
        link = 1'b1;
        wait_left(5, 1);
        do_reset();
        en = 1'b1;
        repeat (150) step(1);

        // Drain: disable and let any frame in flight finish
        en = 1'b0;
        repeat (40) step(0);
        chk("final_queue", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
